// File: rtl/bartlett_sweep_engine.sv
// ============================================================================
//  Module   : bartlett_sweep_engine
//  Brief    : Bartlett beamformer power sweep, P(theta) = Re{a^H Rxx a},
//             single time-multiplexed complex MAC with sweep peak tracking.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bartlett_sweep_engine #(
    parameter int  NUM_SIZE    = 32,
    parameter int  N_CH        = 4,
    parameter int  THETA_COUNT = 19,
    localparam int TW          = $clog2(THETA_COUNT)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [N_CH*N_CH*NUM_SIZE-1:0] s_axis_r_tdata,
    input  logic                          s_axis_r_tvalid,
    output logic                          s_axis_r_tready,
    input  logic [N_CH*NUM_SIZE-1:0]      s_axis_a_tdata,
    input  logic                          s_axis_a_tvalid,
    input  logic                          s_axis_a_tlast,
    output logic                          s_axis_a_tready,
    output logic [2*NUM_SIZE-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tuser,
    output logic                          m_axis_tlast,
    input  logic                          m_axis_tready,
    output logic                          peak_valid,
    output logic [TW-1:0]                 peak_index,
    output logic [2*NUM_SIZE-1:0]         peak_power
);

    localparam int H   = NUM_SIZE / 2;
    localparam int YW  = H + $clog2(N_CH) + 1;
    localparam int PWD = 2 * NUM_SIZE;
    localparam int CW  = $clog2(N_CH);
    localparam int RW  = $clog2(N_CH * N_CH);
    localparam int NR  = N_CH * N_CH;

    localparam logic [CW-1:0] C_LAST_CH    = CW'(N_CH - 1);
    localparam logic [TW-1:0] C_THETA_LAST = TW'(THETA_COUNT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT_A = 3'd1,
        S_MAC_RA = 3'd2,
        S_MAC_AY = 3'd3,
        S_OUT    = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic signed [H-1:0]   r_rre [NR];
    logic signed [H-1:0]   r_rim [NR];
    logic signed [H-1:0]   r_are [N_CH];
    logic signed [H-1:0]   r_aim [N_CH];
    logic signed [YW-1:0]  r_yr  [N_CH];
    logic signed [YW-1:0]  r_yi  [N_CH];
    logic signed [PWD-1:0] r_p;
    logic signed [PWD-1:0] r_peak_power;
    logic [TW-1:0]         r_peak_index;
    logic                  r_peak_valid;
    logic [TW-1:0]         r_theta;
    logic                  r_last;
    logic [CW-1:0]         r_i;
    logic [CW-1:0]         r_j;
    logic [RW-1:0]         r_k;

    logic w_r_hs;
    logic w_a_hs;
    logic w_out_hs;

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        s_axis_r_tready = 1'b0;
        s_axis_a_tready = 1'b0;
        m_axis_tvalid   = 1'b0;
        m_axis_tuser    = 1'b0;
        m_axis_tlast    = 1'b0;
        case (r_state)
            S_IDLE: begin
                s_axis_r_tready = 1'b1;
                if (s_axis_r_tvalid) begin
                    w_state_nxt = S_WAIT_A;
                end
            end
            S_WAIT_A: begin
                s_axis_a_tready = 1'b1;
                if (s_axis_a_tvalid) begin
                    w_state_nxt = S_MAC_RA;
                end
            end
            S_MAC_RA: begin
                if (r_i == C_LAST_CH && r_j == C_LAST_CH) begin
                    w_state_nxt = S_MAC_AY;
                end
            end
            S_MAC_AY: begin
                if (r_i == C_LAST_CH) begin
                    w_state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                m_axis_tvalid = 1'b1;
                m_axis_tuser  = (r_theta == '0);
                m_axis_tlast  = r_last;
                if (m_axis_tready) begin
                    w_state_nxt = r_last ? S_IDLE : S_WAIT_A;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_r_hs   = s_axis_r_tvalid & s_axis_r_tready;
    assign w_a_hs   = s_axis_a_tvalid & s_axis_a_tready;
    assign w_out_hs = m_axis_tvalid & m_axis_tready;

    // ------------------------------------------------------------------------
    // Stage 1 operands: y_i += (R_ij * a_j) >>> (H-1), each partial product
    // shifted on its own before it joins the accumulator.
    // ------------------------------------------------------------------------
    logic signed [H-1:0]        w_rre;
    logic signed [H-1:0]        w_rim;
    logic signed [H-1:0]        w_are_j;
    logic signed [H-1:0]        w_aim_j;
    logic signed [NUM_SIZE-1:0] w_p_rr;
    logic signed [NUM_SIZE-1:0] w_p_ii;
    logic signed [NUM_SIZE-1:0] w_p_ri;
    logic signed [NUM_SIZE-1:0] w_p_ir;
    logic signed [NUM_SIZE-1:0] w_s_rr;
    logic signed [NUM_SIZE-1:0] w_s_ii;
    logic signed [NUM_SIZE-1:0] w_s_ri;
    logic signed [NUM_SIZE-1:0] w_s_ir;
    logic signed [YW-1:0]       w_yr_nxt;
    logic signed [YW-1:0]       w_yi_nxt;

    assign w_rre    = r_rre[r_k];
    assign w_rim    = r_rim[r_k];
    assign w_are_j  = r_are[r_j];
    assign w_aim_j  = r_aim[r_j];
    assign w_p_rr   = NUM_SIZE'(w_rre) * NUM_SIZE'(w_are_j);
    assign w_p_ii   = NUM_SIZE'(w_rim) * NUM_SIZE'(w_aim_j);
    assign w_p_ri   = NUM_SIZE'(w_rre) * NUM_SIZE'(w_aim_j);
    assign w_p_ir   = NUM_SIZE'(w_rim) * NUM_SIZE'(w_are_j);
    assign w_s_rr   = w_p_rr >>> (H - 1);
    assign w_s_ii   = w_p_ii >>> (H - 1);
    assign w_s_ri   = w_p_ri >>> (H - 1);
    assign w_s_ir   = w_p_ir >>> (H - 1);
    assign w_yr_nxt = r_yr[r_i] + YW'(w_s_rr) - YW'(w_s_ii);
    assign w_yi_nxt = r_yi[r_i] + YW'(w_s_ri) + YW'(w_s_ir);

    // Stage 2: Re{conj(a_i) * y_i}, full precision
    logic signed [PWD-1:0] w_ay_r;
    logic signed [PWD-1:0] w_ay_i;

    assign w_ay_r = PWD'(r_are[r_i]) * PWD'(r_yr[r_i]);
    assign w_ay_i = PWD'(r_aim[r_i]) * PWD'(r_yi[r_i]);

    // ------------------------------------------------------------------------
    // Datapath and peak tracker
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NR; k++) begin
                r_rre[k] <= '0;
                r_rim[k] <= '0;
            end
            for (int c = 0; c < N_CH; c++) begin
                r_are[c] <= '0;
                r_aim[c] <= '0;
                r_yr[c]  <= '0;
                r_yi[c]  <= '0;
            end
            r_p          <= '0;
            r_peak_power <= '0;
            r_peak_index <= '0;
            r_peak_valid <= 1'b0;
            r_theta      <= '0;
            r_last       <= 1'b0;
            r_i          <= '0;
            r_j          <= '0;
            r_k          <= '0;
        end else begin
            r_peak_valid <= 1'b0;

            if (w_r_hs) begin
                for (int k = 0; k < NR; k++) begin
                    r_rre[k] <= s_axis_r_tdata[k*NUM_SIZE +: H];
                    r_rim[k] <= s_axis_r_tdata[k*NUM_SIZE+H +: H];
                end
                r_theta <= '0;
            end

            if (w_a_hs) begin
                for (int c = 0; c < N_CH; c++) begin
                    r_are[c] <= s_axis_a_tdata[c*NUM_SIZE +: H];
                    r_aim[c] <= s_axis_a_tdata[c*NUM_SIZE+H +: H];
                    r_yr[c]  <= '0;
                    r_yi[c]  <= '0;
                end
                // The final allowed theta always closes the sweep
                r_last <= s_axis_a_tlast | (r_theta == C_THETA_LAST);
                r_p    <= '0;
                r_i    <= '0;
                r_j    <= '0;
                r_k    <= '0;
            end

            if (r_state == S_MAC_RA) begin
                r_yr[r_i] <= w_yr_nxt;
                r_yi[r_i] <= w_yi_nxt;
                r_k       <= r_k + RW'(1);
                if (r_j == C_LAST_CH) begin
                    r_j <= '0;
                    r_i <= (r_i == C_LAST_CH) ? '0 : r_i + CW'(1);
                end else begin
                    r_j <= r_j + CW'(1);
                end
            end

            if (r_state == S_MAC_AY) begin
                r_p <= r_p + w_ay_r + w_ay_i;
                r_i <= (r_i == C_LAST_CH) ? '0 : r_i + CW'(1);
            end

            if (w_out_hs) begin
                // Strict compare keeps the earliest index on ties
                if (r_theta == '0 || r_p > r_peak_power) begin
                    r_peak_power <= r_p;
                    r_peak_index <= r_theta;
                end
                if (r_last) begin
                    r_peak_valid <= 1'b1;
                end else begin
                    r_theta <= r_theta + TW'(1);
                end
            end
        end
    end

    assign m_axis_tdata = r_p;
    assign peak_valid   = r_peak_valid;
    assign peak_index   = r_peak_index;
    assign peak_power   = r_peak_power;

endmodule

`default_nettype wire
